// File: rtl/sym_seq_pkg.sv
// Shared types and helpers for the 2-bit symbol sequence detector.
package sym_seq_pkg;

  localparam int unsigned SYM_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Increment v by one unless it has already reached max_v.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sym_cmp2.sv
// Combinational full-width equality compare of two 2-bit symbols.
module sym_cmp2
  import sym_seq_pkg::*;
(
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic             eq_c
);

  // Both bits must agree.
  assign eq_c = (a == b);

endmodule

// File: rtl/sym_seq_detect.sv
// Programmable 2-bit symbol sequence detector with saturating hit count.
// Optional build macro SYM_SEQ_DETECT_MISS_CNT_EN adds a saturating count of
// mismatches seen while tracking (miss_cnt).
module sym_seq_detect
  import sym_seq_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         cfg_we,
  input  logic [$clog2(SEQ_LEN)-1:0]   cfg_idx,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  output logic                         det,
  output logic [CNT_W-1:0]             det_cnt,
  output logic [$clog2(SEQ_LEN+1)-1:0] match_idx,
  output logic                         busy
`ifdef SYM_SEQ_DETECT_MISS_CNT_EN
  ,
  output logic [CNT_W-1:0]             miss_cnt
`endif
);

  localparam int unsigned IDX_W   = $clog2(SEQ_LEN);
  localparam int unsigned MIDX_W  = $clog2(SEQ_LEN + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [SYM_W-1:0] pattern [SEQ_LEN];
  state_t           state;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_hit_c;
  logic             first_hit_c;
  logic             last_c;

  // match_idx never reaches SEQ_LEN while tracking, so truncation is safe.
  assign cur_idx = IDX_W'(match_idx);
  assign last_c  = (match_idx == MIDX_W'(SEQ_LEN - 1));

  sym_cmp2 u_cmp_cur (
    .a    (in_sym),
    .b    (pattern[cur_idx]),
    .eq_c (cur_hit_c)
  );

  sym_cmp2 u_cmp_first (
    .a    (in_sym),
    .b    (pattern[0]),
    .eq_c (first_hit_c)
  );

  // Pattern registers; writes are dropped while a sequence is being tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_LEN; i++) pattern[i] <= '0;
    end else if (cfg_we && !busy && (32'(cfg_idx) < SEQ_LEN)) begin
      pattern[cfg_idx] <= cfg_sym;
    end
  end

  // Detector FSM with registered det pulse, progress index and hit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_idx <= '0;
      det       <= 1'b0;
      det_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      det <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        match_idx <= '0;
        busy      <= 1'b0;
      end else if (in_valid) begin
        case (state)
          IDLE: begin
            if (first_hit_c) begin
              state     <= TRACK;
              match_idx <= MIDX_W'(1);
              busy      <= 1'b1;
            end
          end
          TRACK: begin
            if (cur_hit_c) begin
              if (last_c) begin
                state     <= IDLE;
                match_idx <= '0;
                busy      <= 1'b0;
                det       <= 1'b1;
                det_cnt   <= CNT_W'(sat_inc(32'(det_cnt), CNT_MAX));
              end else begin
                match_idx <= match_idx + MIDX_W'(1);
              end
            end else if (first_hit_c) begin
              match_idx <= MIDX_W'(1);
            end else begin
              state     <= IDLE;
              match_idx <= '0;
              busy      <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            match_idx <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SYM_SEQ_DETECT_MISS_CNT_EN
  logic track_miss_c;

  assign track_miss_c = en && in_valid && (state == TRACK) && !cur_hit_c;

  // Saturating count of mismatches while tracking, restarts included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (track_miss_c) begin
      miss_cnt <= CNT_W'(sat_inc(32'(miss_cnt), CNT_MAX));
    end
  end
`endif

endmodule

// File: tb/tb_sym_seq_detect.sv
// Directed self-checking bench for sym_seq_detect (default counter and a 2-bit counter instance).
module tb_sym_seq_detect;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [1:0] cfg_sym;
  logic       in_valid;
  logic [1:0] in_sym;

  logic       det;
  logic [7:0] det_cnt;
  logic [2:0] match_idx;
  logic       busy;
  logic       det2;
  logic [1:0] det_cnt2;
  logic [2:0] match_idx2;
  logic       busy2;
`ifdef SYM_SEQ_DETECT_MISS_CNT_EN
  logic [7:0] miss_cnt;
  logic [1:0] miss_cnt2;
`endif

  int checks;
  int errors;
  int exp_cnt;

  sym_seq_detect #(.SEQ_LEN(4), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sym   (cfg_sym),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .det       (det),
    .det_cnt   (det_cnt),
    .match_idx (match_idx),
    .busy      (busy)
`ifdef SYM_SEQ_DETECT_MISS_CNT_EN
    ,
    .miss_cnt  (miss_cnt)
`endif
  );

  sym_seq_detect #(.SEQ_LEN(4), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sym   (cfg_sym),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .det       (det2),
    .det_cnt   (det_cnt2),
    .match_idx (match_idx2),
    .busy      (busy2)
`ifdef SYM_SEQ_DETECT_MISS_CNT_EN
    ,
    .miss_cnt  (miss_cnt2)
`endif
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [1:0] s);
    in_valid = 1'b1;
    in_sym   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [1:0] s);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_sym = s;
    step();
    cfg_we  = 1'b0;
  endtask

  // Compare both instances against the expected detector state.
  task automatic st(input string tag, input logic d, input int idx, input logic b);
    int exp_cnt2;
    exp_cnt2 = (exp_cnt > 3) ? 3 : exp_cnt;
    chk({tag, ".det"},   32'(det),       32'(d));
    chk({tag, ".idx"},   32'(match_idx), 32'(idx));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".cnt"},   32'(det_cnt),   32'(exp_cnt));
    chk({tag, ".det2"},  32'(det2),      32'(d));
    chk({tag, ".idx2"},  32'(match_idx2), 32'(idx));
    chk({tag, ".cnt2"},  32'(det_cnt2),  32'(exp_cnt2));
  endtask

  // Full 2,1,3,0 pattern ending in a detection and a quiet follow-up cycle.
  task automatic full_seq(input string tag);
    sym(2'd2);
    sym(2'd1);
    sym(2'd3);
    st({tag, ".pre"}, 1'b0, 3, 1'b1);
    sym(2'd0);
    exp_cnt++;
    st({tag, ".hit"}, 1'b1, 0, 1'b0);
    step();
    st({tag, ".after"}, 1'b0, 0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    cfg_we   = 1'b0;
    cfg_idx  = '0;
    cfg_sym  = '0;
    in_valid = 1'b0;
    in_sym   = '0;
    repeat (3) step();
    st("reset", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    step();
    st("post_reset", 1'b0, 0, 1'b0);

    // Pattern registers are zero after reset: symbol 0 starts tracking.
    en = 1'b1;
    sym(2'd0);
    st("zero_pat", 1'b0, 1, 1'b1);
    en = 1'b0;
    step();
    st("zero_pat_off", 1'b0, 0, 1'b0);

    cfg(2'd0, 2'd2);
    cfg(2'd1, 2'd1);
    cfg(2'd2, 2'd3);
    cfg(2'd3, 2'd0);
    en = 1'b1;

    // Basic detection.
    sym(2'd2);
    st("t1.first", 1'b0, 1, 1'b1);
    full_seq("t1");

    // Mismatch on the first symbol value restarts at index 1.
    sym(2'd2);
    sym(2'd1);
    sym(2'd2);
    st("t2.restart", 1'b0, 1, 1'b1);
    sym(2'd1);
    sym(2'd3);
    sym(2'd0);
    exp_cnt++;
    st("t2.hit", 1'b1, 0, 1'b0);
    step();
    st("t2.after", 1'b0, 0, 1'b0);

    // Gap with in_valid low holds progress.
    sym(2'd2);
    sym(2'd1);
    repeat (5) step();
    st("t3.gap", 1'b0, 2, 1'b1);
    sym(2'd3);
    sym(2'd0);
    exp_cnt++;
    st("t3.hit", 1'b1, 0, 1'b0);

    // Enable drop mid-sequence aborts without a detection.
    sym(2'd2);
    sym(2'd1);
    sym(2'd3);
    en = 1'b0;
    step();
    st("t4.en_off", 1'b0, 0, 1'b0);
    sym(2'd0);
    st("t4.ignored", 1'b0, 0, 1'b0);
    en = 1'b1;
    sym(2'd0);
    st("t4.no_start", 1'b0, 0, 1'b0);

    // Partial-bit mismatches (1 vs 3, 0 vs 1) fall back to IDLE.
    sym(2'd2);
    sym(2'd1);
    sym(2'd1);
    st("t5.bit1", 1'b0, 0, 1'b0);
    sym(2'd2);
    sym(2'd0);
    st("t5.bit0", 1'b0, 0, 1'b0);

    // Write while busy is dropped.
    sym(2'd2);
    cfg(2'd0, 2'd1);
    st("t6.busy_wr", 1'b0, 1, 1'b1);
    sym(2'd1);
    sym(2'd3);
    sym(2'd0);
    exp_cnt++;
    st("t6.hit", 1'b1, 0, 1'b0);
    sym(2'd1);
    st("t6.old_p0", 1'b0, 0, 1'b0);
    full_seq("t6b");

    // Same-cycle write and first symbol: match uses old pattern[0], write lands.
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_sym  = 2'd1;
    in_valid = 1'b1;
    in_sym   = 2'd2;
    step();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    st("t7.same", 1'b0, 1, 1'b1);
    sym(2'd1);
    sym(2'd3);
    sym(2'd0);
    exp_cnt++;
    st("t7.hit", 1'b1, 0, 1'b0);
    sym(2'd2);
    st("t7.new_p0_a", 1'b0, 0, 1'b0);
    sym(2'd1);
    st("t7.new_p0_b", 1'b0, 1, 1'b1);
    en = 1'b0;
    step();
    cfg(2'd0, 2'd2);
    en = 1'b1;

    // Counter saturation on the 2-bit instance; det keeps pulsing.
    full_seq("t8");
    full_seq("t8b");

    // Asynchronous reset mid-sequence clears pattern too.
    sym(2'd2);
    sym(2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    st("t9.async", 1'b0, 0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    sym(2'd2);
    st("t9.pat_cleared", 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_seq_detect.md
Name: sym_seq_detect

Overview:
- Sequential stage that consumes 2-bit symbol equality results.
- Compares a stream of 2-bit input symbols against a programmable pattern of SEQ_LEN symbols, one symbol per valid cycle.
- Raises a one-cycle detect pulse when the full pattern is matched and keeps a saturating detection count.
- Sits between the 2-bit symbol source and downstream control/status logic.

Parameters:
- SEQ_LEN, 4, pattern length in symbols (2..8).
- CNT_W, 8, width of the saturating detection counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  detector enable; 0 holds the FSM in IDLE and ignores symbols.
- cfg_we  in  1  pattern write strobe.
- cfg_idx  in  $clog2(SEQ_LEN)  pattern slot to write.
- cfg_sym  in  2  symbol value written to slot cfg_idx.
- in_valid  in  1  in_sym is valid this cycle.
- in_sym  in  2  incoming symbol.
- det  out  1  one-cycle pulse on full pattern match.
- det_cnt  out  CNT_W  number of detections, saturating.
- match_idx  out  $clog2(SEQ_LEN+1)  symbols currently matched.
- busy  out  1  high while in state TRACK.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: pattern regs 0, state IDLE, match_idx 0, det 0, det_cnt 0, busy 0.
- FSM states:
  - IDLE: entered at reset or when en=0.
  - TRACK: entered when en=1 and in_valid=1 and in_sym==pattern[0].
- Transitions in TRACK, evaluated on cycles with in_valid=1:
  - in_sym==pattern[match_idx]: match_idx increments.
  - Increment reaches SEQ_LEN: det=1 next cycle, det_cnt increments, match_idx returns to 0 and state returns to IDLE. Matches are non-overlapping.
  - Mismatch where in_sym==pattern[0]: match_idx=1, stay in TRACK (restart on first symbol only, no general overlap search).
  - Any other mismatch: match_idx=0, go to IDLE.
- in_valid=0: state and match_idx hold. Gaps between symbols are allowed.
- Latency: det asserts on the clock edge after the final matching symbol is sampled (registered output). det is never high on two consecutive cycles.
- det_cnt saturates at 2^CNT_W-1 and never wraps.
- en deassert mid-sequence: next edge goes to IDLE, match_idx=0, no det. det_cnt is retained.
- Configuration:
  - cfg_we takes effect on the next edge.
  - Writes are accepted only when busy=0. Writes while busy=1 are dropped.
  - cfg_we and a first-symbol match in the same cycle: the match uses the old pattern[0].
- Asynchronous reset mid-sequence clears everything immediately, including pattern registers.
- Equality per symbol is a full 2-bit compare: both bits must be equal.

Optional Feature:
- Macro: SYM_SEQ_DETECT_MISS_CNT_EN.
- Defined:
  - Adds output miss_cnt (CNT_W, reset 0).
  - miss_cnt is a saturating count of TRACK-state mismatches, including the restart-on-first-symbol case.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package sym_seq_pkg:
  - state typedef {IDLE, TRACK}
  - SYM_W=2 constant
  - saturating-increment function
- One natural sub-module: sym_cmp2, a combinational 2-bit symbol equality compare. Instantiate it twice, once for pattern[match_idx] and once for pattern[0].

Test Plan:
- Reset, then pattern {2,1,3,0}, en=1, stream 2,1,3,0 → det=1 one cycle after symbol 0; det_cnt=1; busy low afterwards.
- Stream 2,1,2,1,3,0 → mismatch at the third symbol restarts with match_idx=1; det once; det_cnt=1.
- Stream 2,1 then in_valid=0 for 5 cycles then 3,0 → match_idx holds at 2 across the gap; det once.
- Stream 2,1,3 then en=0 then 0 → no det; match_idx=0; state IDLE.
- CNT_W=2, five full patterns → det_cnt saturates at 3; det still pulses 5 times.
- cfg_we to slot 0 with value 1 while busy=1 → write dropped; pattern[0] stays 2; the following sequence 2,1,3,0 still detects.
